// File: rtl/alu_result_buffer_if.sv
// ----------------------------------------------------------------------------
// alu_result_buffer_if
//
// Purpose:
//   This interface bundles the signals between the ALU result buffer and the
//   logic around it. On one side the ALU produces results. On the other side
//   the write-back / PC-update logic consumes them. The interface also carries
//   the hold (ALUOut) register view and the occupancy count.
//
// Parameters:
//   DATA_W : width of an ALU result
//   PTR_W  : log2 of the buffer depth (count is PTR_W+1 bits wide)
//
// Signals:
//   in_data/in_zero/in_ctrl  : ALU result, zero flag, ALUControl code
//   in_valid / in_ready      : producer-side handshake
//   out_data/out_zero/out_neg/out_ctrl : head-of-queue result
//   out_valid / out_ready    : consumer-side handshake
//   hold_data / hold_zero    : most recently consumed result
//   count                    : number of occupied entries
//
// Modports:
//   master : the CPU side (drives the inputs and out_ready)
//   slave  : the buffer itself
// ----------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int DATA_W = 32,
    parameter int PTR_W  = 1
);
    logic [DATA_W-1:0] in_data;
    logic              in_zero;
    logic [3:0]        in_ctrl;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_neg;
    logic [3:0]        out_ctrl;
    logic              out_valid;
    logic              out_ready;

    logic [DATA_W-1:0] hold_data;
    logic              hold_zero;
    logic [PTR_W:0]    count;

    modport master (
        output in_data, in_zero, in_ctrl, in_valid, out_ready,
        input  in_ready, out_data, out_zero, out_neg, out_ctrl, out_valid,
        input  hold_data, hold_zero, count
    );

    modport slave (
        input  in_data, in_zero, in_ctrl, in_valid, out_ready,
        output in_ready, out_data, out_zero, out_neg, out_ctrl, out_valid,
        output hold_data, hold_zero, count
    );
endinterface

// File: rtl/alu_result_buffer.sv
// ----------------------------------------------------------------------------
// alu_result_buffer
//
// Purpose:
//   This block captures each ALU result: the data value, the zero flag and the
//   ALUControl code. It queues the results in a small FIFO that uses
//   valid/ready handshakes. It also keeps an ALUOut-style hold register that
//   holds the last result the consumer took.
//
// Parameters:
//   DATA_W : width of the ALU result
//   DEPTH  : number of FIFO entries (a power of two, at least 2)
//   PTR_W  : log2(DEPTH)
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : alu_result_buffer_if.slave. It carries the input handshake, the
//            head-of-queue outputs, the hold register and the count.
//
// Optional feature (macro ALU_RESULT_BYPASS_EN):
//   This applies when the buffer is empty, in_valid=1 and out_ready=1.
//   - The input flows combinationally to the out_* ports.
//   - The result is not written into the FIFO.
//   - The hold register loads the result on that edge.
//   When the macro is undefined, every result takes at least one cycle to pass
//   through.
// ----------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_buffer_if.slave   bus
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Storage. Each entry is small and the head is read combinationally,
    // so the storage is kept in plain registers indexed by rd_ptr.
    // Entries are never cleared, because out_valid gates everything.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_zero [DEPTH];
    logic [3:0]        r_mem_ctrl [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_zero;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_in_ready;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // in_ready comes only from registered state. This avoids a
    // combinational path from out_ready back to the producer.
    assign w_in_ready = ~w_full;

`ifdef ALU_RESULT_BYPASS_EN
    assign w_bypass = w_empty & bus.in_valid & bus.out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed result goes straight to the consumer. It never occupies
    // an entry.
    assign w_push = bus.in_valid & w_in_ready & ~w_bypass;
    assign w_pop  = ~w_empty & bus.out_ready;

    // ------------------------------------------------------------------
    // One-hot write enables, one per entry
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_wr_en;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push & (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) begin
                    r_mem_data[i] <= bus.in_data;
                    r_mem_zero[i] <= bus.in_zero;
                    r_mem_ctrl[i] <= bus.in_ctrl;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap modulo DEPTH on their own.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head-of-queue view. All fields read as zero when nothing is valid.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_zero;
    logic [3:0]        w_head_ctrl;
    logic              w_head_valid;

    always_comb begin
        w_head_data  = '0;
        w_head_zero  = 1'b0;
        w_head_ctrl  = '0;
        w_head_valid = 1'b0;
        if (w_bypass) begin
            w_head_data  = bus.in_data;
            w_head_zero  = bus.in_zero;
            w_head_ctrl  = bus.in_ctrl;
            w_head_valid = 1'b1;
        end else if (!w_empty) begin
            w_head_data  = r_mem_data[r_rd_ptr];
            w_head_zero  = r_mem_zero[r_rd_ptr];
            w_head_ctrl  = r_mem_ctrl[r_rd_ptr];
            w_head_valid = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hold register. It captures whatever the consumer takes on this edge,
    // whether that is a queued entry or a bypassed result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_data <= '0;
            r_hold_zero <= 1'b0;
        end else if (w_bypass || w_pop) begin
            r_hold_data <= w_head_data;
            r_hold_zero <= w_head_zero;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_head_valid;
    assign bus.out_data  = w_head_data;
    assign bus.out_zero  = w_head_zero;
    assign bus.out_ctrl  = w_head_ctrl;
    assign bus.out_neg   = w_head_data[DATA_W-1];
    assign bus.hold_data = r_hold_data;
    assign bus.hold_zero = r_hold_zero;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_alu_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_alu_result_buffer
//
// The bench applies two kinds of stimulus to alu_result_buffer:
//   - directed sequences that follow the test plan
//   - a run of randomized cycles
// It predicts every output with a queue-based reference model of the FIFO.
// ----------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int PTR_W  = 1;

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic [3:0]  c;
    } entry_t;

    logic clk = 1'b0;
    logic reset;

    alu_result_buffer_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    entry_t      q[$];
    logic [31:0] m_hold_data = '0;
    logic        m_hold_zero = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // This task runs one clock cycle:
    //   1. Drive the inputs on the falling edge.
    //   2. Check every output against the model.
    //   3. Let the rising edge happen.
    //   4. Advance the model.
    task automatic step(input bit rst, input bit iv, input logic [31:0] d,
                        input bit z, input logic [3:0] c, input bit ordy);
        int          cnt;
        bit          byp;
        bit          push;
        bit          pop;
        bit          ev;
        logic [31:0] ed;
        logic        ez;
        logic [3:0]  ec;
        entry_t      e;

        @(negedge clk);
        reset         = rst;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_zero   = z;
        bus.in_ctrl   = c;
        bus.out_ready = ordy;
        #1;

        cnt = q.size();
        byp = 1'b0;
`ifdef ALU_RESULT_BYPASS_EN
        byp = (cnt == 0) && iv && ordy;
`endif
        ev = 1'b0; ed = '0; ez = 1'b0; ec = '0;
        if (byp) begin
            ev = 1'b1; ed = d; ez = z; ec = c;
        end else if (cnt > 0) begin
            ev = 1'b1; ed = q[0].d; ez = q[0].z; ec = q[0].c;
        end

        check_val("in_ready",  64'(bus.in_ready),  64'(cnt != DEPTH));
        check_val("out_valid", 64'(bus.out_valid), 64'(ev));
        check_val("out_data",  64'(bus.out_data),  64'(ed));
        check_val("out_zero",  64'(bus.out_zero),  64'(ez));
        check_val("out_neg",   64'(bus.out_neg),   64'(ed[31]));
        check_val("out_ctrl",  64'(bus.out_ctrl),  64'(ec));
        check_val("hold_data", 64'(bus.hold_data), 64'(m_hold_data));
        check_val("hold_zero", 64'(bus.hold_zero), 64'(m_hold_zero));
        check_val("count",     64'(bus.count),     64'(cnt));

        @(posedge clk);
        if (rst) begin
            q.delete();
            m_hold_data = '0;
            m_hold_zero = 1'b0;
        end else if (byp) begin
            m_hold_data = d;
            m_hold_zero = z;
        end else begin
            push = iv && (cnt < DEPTH);
            pop  = ordy && (cnt > 0);
            if (pop) begin
                e = q.pop_front();
                m_hold_data = e.d;
                m_hold_zero = e.z;
            end
            if (push) begin
                e.d = d; e.z = z; e.c = c;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_zero   = 1'b0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Check the reset state, then push 5 and pop it
        step(0, 1, 32'h5, 0, 4'b0000, 0);
        step(0, 0, 32'h0, 0, 4'b0000, 1);
        step(0, 0, 32'h0, 0, 4'b0000, 0);

        // Fill the buffer, try to push while full, then drain
        step(0, 1, 32'hFFFF_FFFE, 0, 4'b0001, 0);
        step(0, 1, 32'h0, 1, 4'b0010, 0);
        step(0, 1, 32'h77, 0, 4'b0011, 0);
        step(0, 0, 32'h0, 0, 4'b0000, 1);
        step(0, 0, 32'h0, 0, 4'b0000, 1);
        step(0, 0, 32'h0, 0, 4'b0000, 0);

        // Push and pop in the same cycle at count=1
        step(0, 1, 32'hA, 0, 4'b0100, 0);
        step(0, 1, 32'h10, 0, 4'b0101, 1);
        step(0, 0, 32'h0, 0, 4'b0000, 1);

        // Back-to-back push/pop pairs with values 1..6; both pointers wrap
        step(0, 1, 32'h1, 0, 4'h1, 0);
        for (int k = 2; k <= 6; k++) begin
            step(0, 1, 32'(k), 0, 4'(k), 1);
        end
        step(0, 0, 32'h0, 0, 4'h0, 1);
        step(0, 0, 32'h0, 0, 4'h0, 0);

        // Fill with two entries, then assert reset while in_valid is high
        step(0, 1, 32'h21, 0, 4'h2, 0);
        step(0, 1, 32'h22, 1, 4'h3, 0);
        step(0, 0, 32'h0, 0, 4'h0, 1);
        step(1, 1, 32'h33, 0, 4'h4, 0);
        step(0, 0, 32'h0, 0, 4'h0, 0);

        // Offer a result when empty with out_ready high (bypass candidate)
        step(0, 1, 32'hA5, 0, 4'h6, 1);
        step(0, 0, 32'h0, 0, 4'h0, 0);
        step(0, 0, 32'h0, 0, 4'h0, 1);

        // Randomized traffic with an occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), rd,
                 (rd == 32'h0), 4'($urandom_range(0, 15)), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Sits directly downstream of the main ALU in the multi-cycle CPU and captures each ALU result (32-bit value, zero flag, 4-bit ALU control code).
- Queues results in a small FIFO with valid/ready handshakes toward the write-back / PC-update logic.
- Keeps an ALUOut-style hold register containing the most recently consumed result, readable in later cycles of the same instruction.

Parameters:
- DATA_W, 32, width of ALU result.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- PTR_W, 1, log2(DEPTH); must be consistent with DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  ALU result (ALUout).
- in_zero  input  1  ALU zero flag.
- in_ctrl  input  4  ALUControl code that produced in_data.
- in_valid  input  1  producer offers a result this cycle.
- in_ready  output  1  buffer can accept.
- out_data  output  DATA_W  head-of-queue result.
- out_zero  output  1  head zero flag.
- out_neg  output  1  out_data[DATA_W-1].
- out_ctrl  output  4  head control code.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer takes head this cycle.
- hold_data  output  DATA_W  last consumed result.
- hold_zero  output  1  zero flag of last consumed result.
- count  output  PTR_W+1  occupied entries.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0.
  - out_valid=0, in_ready=1.
  - out_data=0, out_zero=0, out_neg=0, out_ctrl=0.
  - hold_data=0, hold_zero=0.
  - Storage contents need not be cleared.
- Reset mid-operation discards all queued entries; a push or pop in the reset cycle is ignored.
- Push:
  - Occurs when in_valid && in_ready.
  - Writes {in_data, in_zero, in_ctrl} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when out_valid && out_ready.
  - rd_ptr increments modulo DEPTH.
  - hold_data/hold_zero load the popped entry on the same edge.
- Readiness and validity:
  - in_ready = (count != DEPTH). It is registered-state-derived only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Head outputs:
  - out_data/out_zero/out_ctrl show the entry at rd_ptr while out_valid=1.
  - All are 0 when empty; out_neg follows out_data.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - The same-cycle case is legal at any nonzero count below DEPTH; when full, no push occurs.
- Latency: a result pushed at edge N is visible at out_data after edge N (1 cycle). FIFO order is strict.
- Full: in_valid held with in_ready=0 leaves the buffer unchanged; the producer must hold its data.
- Empty: out_ready with out_valid=0 has no effect; hold_data is unchanged.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0; ordering is preserved across the wrap.
- Data is stored unmodified; no arithmetic is performed on it.

Optional Feature:
- Macro: ALU_RESULT_BYPASS_EN.
- Defined:
  - When count=0, in_valid=1 and out_ready=1, the input passes combinationally to the out_* ports with out_valid=1 in the same cycle.
  - The entry is not written to the FIFO, and hold_data/hold_zero load it on that edge.
  - Pointers and count are unchanged.
  - In this cycle out_valid = in_valid when count=0.
- Undefined: no bypass; the minimum latency is always 1 cycle, as specified above.

Test Plan:
- Reset then push {32'h0000_0005, zero=0, ctrl=4'b0000}: after 1 edge, out_valid=1, out_data=5, count=1. Pop: out_valid=0, hold_data=5, out_data=0.
- Push 32'hFFFF_FFFE (ctrl 4'b0001), then 32'h0 (zero=1), with out_ready=0: count=2, in_ready=0. A third push with in_valid=1 is not accepted. Pops return FFFF_FFFE with out_neg=1, then 0 with out_zero=1.
- At count=1, push 32'h10 and pop simultaneously: count stays 1, popped value goes to hold_data, and the new head is 32'h10.
- Six back-to-back push/pop pairs with values 1..6: output order is 1..6 and both pointers wrap cleanly.
- Fill with 2 entries, assert reset for 1 cycle together with in_valid: count=0, out_valid=0, hold_data=0, and the input is not captured.
- With ALU_RESULT_BYPASS_EN, empty buffer, in_valid=1, out_ready=1, in_data=32'hA5: out_data=A5 in the same cycle, count stays 0, hold_data=A5 after the edge. Without the macro, out_data=0 in that cycle and A5 appears one cycle later.
